// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared requester IDs and request bundle for the memory port arbiter
package mem_arb_pkg;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with a registered last-winner pointer
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic cpu_req_i,
    input  logic ldr_req_i,
    output logic cpu_gnt_o,
    output logic ldr_gnt_o
);

    logic last_q;
    logic last_d;

    // On a tie the requester that did not win last time is favoured.
    always_comb begin
        cpu_gnt_o = 1'b0;
        ldr_gnt_o = 1'b0;
        if (cpu_req_i && ldr_req_i) begin
            if (last_q == REQ_CPU) begin
                ldr_gnt_o = 1'b1;
            end else begin
                cpu_gnt_o = 1'b1;
            end
        end else begin
            cpu_gnt_o = cpu_req_i;
            ldr_gnt_o = ldr_req_i;
        end

        last_d = last_q;
        if (cpu_gnt_o) begin
            last_d = REQ_CPU;
        end else if (ldr_gnt_o) begin
            last_d = REQ_LDR;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= REQ_LDR;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between the core and the loader
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_SIZE = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    input  logic        l_req,
    input  logic        l_we,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    output logic        l_gnt,
    output logic        l_rvalid,
    output logic [31:0] l_rdata,
    input  logic        l_hold,
    output logic        cpu_stall,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic        oob_err,
    output logic [31:0] oob_addr
);

    localparam logic [29:0] MEM_WORDS = 30'(MEM_SIZE);

    mem_req_t    c_bus;
    mem_req_t    l_bus;
    logic        any_gnt;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        oob_hit;

    logic        c_rvalid_q, c_rvalid_d;
    logic        l_rvalid_q, l_rvalid_d;
    logic [31:0] c_rdata_q,  c_rdata_d;
    logic [31:0] l_rdata_q,  l_rdata_d;
    logic        oob_err_q,  oob_err_d;
    logic [31:0] oob_addr_q, oob_addr_d;

    assign c_bus = {c_req, c_we, c_addr, c_wdata};
    assign l_bus = {l_req, l_we, l_addr, l_wdata};

    // The loader hold masks core eligibility only; in-flight responses are untouched.
    rr_arb2 u_rr_arb2 (
        .clk_i     (clk),
        .rst_i     (reset),
        .cpu_req_i (c_bus.req & ~l_hold),
        .ldr_req_i (l_bus.req),
        .cpu_gnt_o (c_gnt),
        .ldr_gnt_o (l_gnt)
    );

    assign any_gnt   = c_gnt | l_gnt;
    assign sel_we    = l_gnt ? l_bus.we    : c_bus.we;
    assign sel_addr  = l_gnt ? l_bus.addr  : c_bus.addr;
    assign sel_wdata = l_gnt ? l_bus.wdata : c_bus.wdata;

    assign mem_we    = any_gnt & sel_we;
    assign mem_a     = sel_addr;
    assign mem_wd    = sel_wdata;
    assign cpu_stall = c_req & ~c_gnt;
    assign oob_hit   = any_gnt && (sel_addr[31:2] >= MEM_WORDS);

    always_comb begin
        c_rvalid_d = c_gnt;
        l_rvalid_d = l_gnt;
        c_rdata_d  = (c_gnt && !c_we) ? mem_rd : c_rdata_q;
        l_rdata_d  = (l_gnt && !l_we) ? mem_rd : l_rdata_q;
        oob_err_d  = oob_err_q;
        oob_addr_d = oob_addr_q;
        // Only the first out-of-range access is recorded.
        if (oob_hit && !oob_err_q) begin
            oob_err_d  = 1'b1;
            oob_addr_d = sel_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_rvalid_q <= 1'b0;
            l_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            l_rdata_q  <= '0;
            oob_err_q  <= 1'b0;
            oob_addr_q <= '0;
        end else begin
            c_rvalid_q <= c_rvalid_d;
            l_rvalid_q <= l_rvalid_d;
            c_rdata_q  <= c_rdata_d;
            l_rdata_q  <= l_rdata_d;
            oob_err_q  <= oob_err_d;
            oob_addr_q <= oob_addr_d;
        end
    end

    assign c_rvalid = c_rvalid_q;
    assign l_rvalid = l_rvalid_q;
    assign c_rdata  = c_rdata_q;
    assign l_rdata  = l_rdata_q;
    assign oob_err  = oob_err_q;
    assign oob_addr = oob_addr_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single port of the unified instruction/data memory between the multicycle core and the program loader/debug port. It sits between the core's memory interface and the memory (`MemWrite`/`A`/`WD`/`RD`). Per-cycle round-robin arbitration is combined with a loader hold that stalls the core during program load. Each access gets a registered one-cycle response pulse, and out-of-range addresses raise a sticky error.

## Interface
- `MEM_SIZE`, 64 — memory depth in words; matches the memory instance.
- `clk` input 1 — single clock; all state updates on rising edge.
- `reset` input 1 — asynchronous, active-high.
- `c_req` / `c_we` input 1 — core request / write enable.
- `c_addr` / `c_wdata` input 32 — core byte address / write data.
- `c_gnt` output 1 — core request accepted this cycle (combinational).
- `c_rvalid` output 1 — core response pulse, cycle after grant.
- `c_rdata` output 32 — registered read data for core.
- `l_req` / `l_we` input 1 — loader request / write enable.
- `l_addr` / `l_wdata` input 32 — loader address / write data.
- `l_gnt` / `l_rvalid` output 1 — loader grant / response pulse.
- `l_rdata` output 32 — registered read data for loader.
- `l_hold` input 1 — level; while 1, core is never granted.
- `cpu_stall` output 1 — `c_req & ~c_gnt`; drives the core's FSM stall.
- `mem_we` output 1 — to memory `MemWrite`.
- `mem_a` / `mem_wd` output 32 — to memory `A` / `WD`.
- `mem_rd` input 32 — from memory `RD` (combinational read).
- `oob_err` output 1 — sticky: a granted access had `addr[31:2] >= MEM_SIZE`.
- `oob_addr` output 32 — address of first out-of-range access.

## Operation
- One access per cycle. Grant is computed combinationally from `c_req`, `l_req`, `l_hold` and the `last` pointer.
- Eligibility:
  - core eligible = `c_req & ~l_hold`;
  - loader eligible = `l_req`.
- Only one eligible requester: it is granted.
- Both eligible: the requester not equal to `last` is granted.
- `last` updates to the granted ID at the clock edge and holds when idle. Reset value is LOADER, so the core wins the first tie.
- Memory port mux:
  - granted requester's addr/wdata drive `mem_a`/`mem_wd`;
  - `mem_we = gnt & we`;
  - no grant → `mem_we=0`, `mem_a`/`mem_wd` = core's inputs (don't-care, but deterministic).
- Response, registered on the grant edge:
  - `x_rvalid` is set for exactly one cycle for reads and writes (writes get an ack);
  - `x_rdata` captures `mem_rd` on reads only and holds otherwise.
- A write is committed by the memory at the same edge. A read of the same word in the next cycle returns the new data.
- Out of range: the access still proceeds (the memory wraps modulo). On the first occurrence, `oob_err` is set and `oob_addr` latched. Both stay until reset; later violations do not overwrite them.
- `l_hold` asserted while a core response is in flight: the response is still delivered. Hold only blocks new core grants.
- `cpu_stall` is purely combinational.

## Timing
- Reset values:
  - `c_rvalid` = `l_rvalid` = 0;
  - `c_rdata` = `l_rdata` = 0;
  - `oob_err` = 0, `oob_addr` = 0;
  - `last` = LOADER.
- Reset mid-operation: any pending rvalid is dropped, and no spurious pulse follows reset deassertion.
- Latency: grant in cycle N (same cycle as request); rvalid/rdata in cycle N+1.
- Throughput: one access per cycle. Back-to-back grants to the same requester are allowed when the other is idle.
- Requester contract:
  - hold req/we/addr/wdata stable until its gnt is seen;
  - deasserting req without gnt is allowed (request withdrawn).
- Both requesting continuously without hold: grants strictly alternate.

## Structure
- Shared package `mem_arb_pkg`:
  - requester ID constants `REQ_CPU=1'b0`, `REQ_LDR=1'b1`;
  - typedef for the request bundle (req, we, addr, wdata).
- Sub-module `rr_arb2`: 2-way round-robin grant logic plus the `last` register.
- The mux, response registers and OOB tracking stay in the top module.

## Test plan
- Reset asserted then released, no requests → all outputs 0, `mem_we=0`, no rvalid pulses.
- Core writes 0xDEADBEEF to 0x10, then reads 0x10 → `c_gnt` both cycles; `c_rvalid` pulses in cycles N+1 and N+2; `c_rdata=0xDEADBEEF`.
- Both request continuously for 6 cycles, `l_hold=0` → grants C,L,C,L,C,L; each rvalid one cycle after its grant.
- Core request with `l_hold=1` while loader writes 0x20..0x2C → `cpu_stall=1` and `c_gnt=0` throughout; the core is granted the cycle hold drops.
- Loader read at 0x100 (word 64, MEM_SIZE=64) → `oob_err=1`, `oob_addr=0x100`, `l_rdata` = word 0. A later OOB at 0x200 leaves `oob_addr` at 0x100.
- Reset asserted in the cycle after a core read grant → `c_rvalid` stays 0 and `c_rdata=0` after reset.
